// File: rtl/saes_pkg.sv
// ---------------------------------------------------------------------------
// saes_pkg
// Shared types, constants and nibble-level helpers for the S-AES decryption
// slice: FSM state encoding, key-schedule round constants, forward/inverse
// S-boxes and the byte/block permutations built on them.
// ---------------------------------------------------------------------------
package saes_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_R1,
        S_R2,
        S_OUT
    } state_t;

    localparam logic [7:0] RCON1 = 8'h80;
    localparam logic [7:0] RCON2 = 8'h30;

    localparam logic [3:0] SBOX [16] = '{
        4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
        4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'hA, 4'h5, 4'h9, 4'hB, 4'h1, 4'h7, 4'h8, 4'hF,
        4'h6, 4'h0, 4'h2, 4'h3, 4'hC, 4'h4, 4'hD, 4'hE
    };

    function automatic logic [3:0] sbox(input logic [3:0] n);
        return SBOX[n];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] n);
        return INV_SBOX[n];
    endfunction

    function automatic logic [7:0] sub_nib8(input logic [7:0] b);
        return {sbox(b[7:4]), sbox(b[3:0])};
    endfunction

    function automatic logic [7:0] rot_nib8(input logic [7:0] b);
        return {b[3:0], b[7:4]};
    endfunction

    // Nibbles n1 and n3 form the second row of the 2x2 state matrix.
    function automatic logic [15:0] inv_shift_rows16(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    function automatic logic [15:0] inv_sub_nib16(input logic [15:0] s);
        return {inv_sbox(s[15:12]), inv_sbox(s[11:8]),
                inv_sbox(s[7:4]),   inv_sbox(s[3:0])};
    endfunction

endpackage

// File: rtl/saes_decrypt_ctrl_if.sv
// ---------------------------------------------------------------------------
// saes_decrypt_ctrl_if
// Handshake bundle between the ciphertext source, the decryption engine and
// the plaintext consumer.
//   in_valid/in_ready/in_ct/in_key : ciphertext + key input channel
//   out_valid/out_ready/out_pt     : plaintext output channel
//   busy                           : engine is processing a block
// Modports: master = source/consumer side, slave = engine side.
// ---------------------------------------------------------------------------
interface saes_decrypt_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_ct;
    logic [15:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pt;
    logic        busy;

    modport master (
        output in_valid, in_ct, in_key, out_ready,
        input  in_ready, out_valid, out_pt, busy
    );

    modport slave (
        input  in_valid, in_ct, in_key, out_ready,
        output in_ready, out_valid, out_pt, busy
    );
endinterface

// File: rtl/saes_inv_mixcol.sv
// ---------------------------------------------------------------------------
// saes_inv_mixcol
// Combinational 16-bit inverse MixColumns: each column (n0,n1), (n2,n3) is
// multiplied by [[9,2],[2,9]] over GF(2^4) with modulus x^4+x+1.
//   din  : 16-bit state in
//   dout : 16-bit state out
// ---------------------------------------------------------------------------
module saes_inv_mixcol (
    input  logic [15:0] din,
    output logic [15:0] dout
);

    // Shift-and-add multiply; 4'h3 folds x^4 back as x+1.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    assign dout = {gf_mul(4'h9, din[15:12]) ^ gf_mul(4'h2, din[11:8]),
                   gf_mul(4'h2, din[15:12]) ^ gf_mul(4'h9, din[11:8]),
                   gf_mul(4'h9, din[7:4])   ^ gf_mul(4'h2, din[3:0]),
                   gf_mul(4'h2, din[7:4])   ^ gf_mul(4'h9, din[3:0])};

endmodule

// File: rtl/saes_key_expand.sv
// ---------------------------------------------------------------------------
// saes_key_expand
// Combinational S-AES key schedule.
//   key        : 16-bit cipher key
//   k0, k1, k2 : round keys {w0,w1}, {w2,w3}, {w4,w5}
// ---------------------------------------------------------------------------
module saes_key_expand
    import saes_pkg::*;
(
    input  logic [15:0] key,
    output logic [15:0] k0,
    output logic [15:0] k1,
    output logic [15:0] k2
);

    logic [7:0] w0, w1, w2, w3, w4, w5;

    assign w0 = key[15:8];
    assign w1 = key[7:0];
    assign w2 = w0 ^ RCON1 ^ sub_nib8(rot_nib8(w1));
    assign w3 = w2 ^ w1;
    assign w4 = w2 ^ RCON2 ^ sub_nib8(rot_nib8(w3));
    assign w5 = w4 ^ w3;

    assign k0 = {w0, w1};
    assign k1 = {w2, w3};
    assign k2 = {w4, w5};

endmodule

// File: rtl/saes_decrypt_ctrl.sv
// ---------------------------------------------------------------------------
// saes_decrypt_ctrl
// Iterative S-AES decryption engine. One block is processed at a time:
// optional key expansion, round 1, round 2 (the only user of the shared
// inverse-MixColumns unit), then the plaintext is held until consumed.
// The expanded key is cached so a block under the previous key skips S_KEY.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : handshake bundle (engine side), see saes_decrypt_ctrl_if
// Parameter KEY_CACHE: 1 = reuse round keys when in_key matches, 0 = always
// expand.
// ---------------------------------------------------------------------------
module saes_decrypt_ctrl
    import saes_pkg::*;
#(
    parameter int KEY_CACHE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    saes_decrypt_ctrl_if.slave  bus
);

    state_t      state_q, state_d;
    logic [15:0] blk_q;
    logic [15:0] key_q;
    logic [15:0] k0_q, k1_q, k2_q;
    logic        cache_vld_q;
    logic [15:0] out_pt_q;
    logic        out_valid_q;

    logic [15:0] k0_w, k1_w, k2_w;
    logic [15:0] mix_w;
    logic        key_hit;
    logic        in_ready_c;
    logic        busy_c;

    // key_q holds the key of the last accepted block; once S_KEY has run for
    // it (cache_vld_q) the round-key registers match it.
    assign key_hit = (KEY_CACHE != 0) && cache_vld_q && (bus.in_key == key_q);

    saes_key_expand u_key_expand (
        .key (key_q),
        .k0  (k0_w),
        .k1  (k1_w),
        .k2  (k2_w)
    );

    // Output is consumed only in S_R2.
    saes_inv_mixcol u_inv_mixcol (
        .din  (blk_q ^ k1_q),
        .dout (mix_w)
    );

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        busy_c     = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b0;
                if (bus.in_valid) state_d = key_hit ? S_R1 : S_KEY;
            end
            S_KEY:   state_d = S_R1;
            S_R1:    state_d = S_R2;
            S_R2:    state_d = S_OUT;
            S_OUT:   if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            blk_q       <= '0;
            key_q       <= '0;
            k0_q        <= '0;
            k1_q        <= '0;
            k2_q        <= '0;
            cache_vld_q <= 1'b0;
            out_pt_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        blk_q <= bus.in_ct;
                        key_q <= bus.in_key;
                    end
                end
                S_KEY: begin
                    k0_q        <= k0_w;
                    k1_q        <= k1_w;
                    k2_q        <= k2_w;
                    cache_vld_q <= 1'b1;
                end
                S_R1: begin
                    blk_q <= inv_sub_nib16(inv_shift_rows16(blk_q ^ k2_q));
                end
                S_R2: begin
                    out_pt_q    <= inv_sub_nib16(inv_shift_rows16(mix_w)) ^ k0_q;
                    out_valid_q <= 1'b1;
                end
                S_OUT: begin
                    if (bus.out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = busy_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pt    = out_pt_q;

endmodule

// File: tb/tb_saes_decrypt_ctrl.sv
module tb_saes_decrypt_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    saes_decrypt_ctrl_if bus ();
    saes_decrypt_ctrl_if bus0 ();

    saes_decrypt_ctrl #(.KEY_CACHE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Second instance without the key cache, fed the same input stream.
    saes_decrypt_ctrl #(.KEY_CACHE(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    assign bus0.in_valid = bus.in_valid;
    assign bus0.in_ct    = bus.in_ct;
    assign bus0.in_key   = bus.in_key;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int sb  [16] = '{9, 4, 10, 11, 13, 1, 8, 5, 6, 2, 0, 3, 12, 14, 15, 7};
    int isb [16] = '{10, 5, 9, 11, 1, 7, 8, 15, 6, 0, 2, 3, 12, 4, 13, 14};

    // Polynomial product over GF(2)[x], reduced by x^4+x+1 (0x13).
    function automatic int gmul(int a, int b);
        int p;
        p = 0;
        for (int i = 0; i < 4; i++)
            if ((b >> i) & 1) p = p ^ (a << i);
        for (int d = 6; d >= 4; d--)
            if ((p >> d) & 1) p = p ^ (19 << (d - 4));
        return p;
    endfunction

    function automatic int g_fn(int w);
        return (sb[w & 15] << 4) | sb[(w >> 4) & 15];
    endfunction

    function automatic logic [15:0] model_decrypt(input logic [15:0] ct, input logic [15:0] key);
        int w[6];
        int rk[3];
        int n[4];
        int m[4];
        int s;
        w[0] = int'(key[15:8]);
        w[1] = int'(key[7:0]);
        w[2] = w[0] ^ 128 ^ g_fn(w[1]);
        w[3] = w[2] ^ w[1];
        w[4] = w[2] ^ 48 ^ g_fn(w[3]);
        w[5] = w[4] ^ w[3];
        for (int r = 0; r < 3; r++) rk[r] = (w[2*r] << 8) | w[2*r+1];
        s = int'(ct) ^ rk[2];
        for (int i = 0; i < 4; i++) n[i] = (s >> (12 - 4*i)) & 15;
        m[0] = isb[n[0]]; m[1] = isb[n[3]]; m[2] = isb[n[2]]; m[3] = isb[n[1]];
        s = ((m[0] << 12) | (m[1] << 8) | (m[2] << 4) | m[3]) ^ rk[1];
        for (int i = 0; i < 4; i++) n[i] = (s >> (12 - 4*i)) & 15;
        m[0] = gmul(9, n[0]) ^ gmul(2, n[1]);
        m[1] = gmul(2, n[0]) ^ gmul(9, n[1]);
        m[2] = gmul(9, n[2]) ^ gmul(2, n[3]);
        m[3] = gmul(2, n[2]) ^ gmul(9, n[3]);
        n[0] = isb[m[0]]; n[1] = isb[m[3]]; n[2] = isb[m[2]]; n[3] = isb[m[1]];
        s = ((n[0] << 12) | (n[1] << 8) | (n[2] << 4) | n[3]) ^ rk[0];
        return s[15:0];
    endfunction

    // ---------------- helpers ----------------
    // Offers one block with out_ready high on both instances. Latency counts
    // the clock edges after the accept edge up to the first edge at which
    // out_valid is presented (sampled on falling edges).
    task automatic run_block(input logic [15:0] ct, input logic [15:0] key,
                             output int lat, output int lat0,
                             output logic [15:0] pt, output logic [15:0] pt0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_ct    = ct;
        bus.in_key   = key;
        chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0; lat0 = 0; pt = '0; pt0 = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.out_valid && lat == 0) begin
                lat = i;
                pt  = bus.out_pt;
            end
            if (bus0.out_valid && lat0 == 0) begin
                lat0 = i;
                pt0  = bus0.out_pt;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    logic [15:0] pt, pt0, hold_pt, ct_r, key_r;
    int lat, lat0;
    logic [15:0] exp_q[$];
    int sent, rcvd;
    logic extra;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ct     = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b1;
        bus0.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_pt", 32'(bus.out_pt), 32'h0);
        rst_n = 1'b1;

        // Known vector, cache miss then cache hit.
        run_block(16'h0738, 16'hA73B, lat, lat0, pt, pt0);
        chk("kv_miss_pt", 32'(pt), 32'h6F6B);
        chk("kv_miss_lat", 32'(lat), 32'd4);
        chk("kv_nocache_pt", 32'(pt0), 32'h6F6B);
        chk("kv_nocache_lat", 32'(lat0), 32'd4);
        run_block(16'h0738, 16'hA73B, lat, lat0, pt, pt0);
        chk("kv_hit_pt", 32'(pt), 32'h6F6B);
        chk("kv_hit_lat", 32'(lat), 32'd3);
        chk("kv_nocache_rep_lat", 32'(lat0), 32'd4);
        chk("kv_nocache_rep_pt", 32'(pt0), 32'h6F6B);

        // Key change, then reuse of the new key.
        ct_r = 16'($urandom);
        run_block(ct_r, 16'h0000, lat, lat0, pt, pt0);
        chk("keychg_pt", 32'(pt), 32'(model_decrypt(ct_r, 16'h0000)));
        chk("keychg_lat", 32'(lat), 32'd4);
        ct_r = 16'($urandom);
        run_block(ct_r, 16'h0000, lat, lat0, pt, pt0);
        chk("keychg_hit_pt", 32'(pt), 32'(model_decrypt(ct_r, 16'h0000)));
        chk("keychg_hit_lat", 32'(lat), 32'd3);

        // Backpressure on the output channel.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_ct     = 16'h1234;
        bus.in_key    = 16'h0000;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.out_valid) lat = i;
        end
        chk("bp_lat", 32'(lat), 32'd3);
        hold_pt = bus.out_pt;
        chk("bp_pt", 32'(hold_pt), 32'(model_decrypt(16'h1234, 16'h0000)));
        bus.in_valid = 1'b1;
        bus.in_ct    = 16'hBEEF;
        bus.in_key   = 16'h5A5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
            chk("bp_out_pt_held", 32'(bus.out_pt), 32'(hold_pt));
            chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_after_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_after_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_after_pt_kept", 32'(bus.out_pt), 32'(hold_pt));
        extra = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) extra = 1'b1;
        end
        chk("bp_ignored_input", 32'(extra), 32'd0);

        // Reset while a block is in S_R1 (key 0000 is cached: hit).
        do_reset();
        run_block(16'h0738, 16'h0000, lat, lat0, pt, pt0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_ct    = 16'h4321;
        bus.in_key   = 16'h0000;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        extra = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) extra = 1'b1;
        end
        chk("midrst_no_output", 32'(extra), 32'd0);
        run_block(16'h4321, 16'h0000, lat, lat0, pt, pt0);
        chk("midrst_next_lat", 32'(lat), 32'd4);
        chk("midrst_next_pt", 32'(pt), 32'(model_decrypt(16'h4321, 16'h0000)));

        // Randomised sweep with random output backpressure.
        sent = 0;
        rcvd = 0;
        key_r = 16'($urandom);
        fork
            begin : driver
                for (int b = 0; b < 1000; b++) begin
                    int wait_cyc;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    @(negedge clk);
                    if ($urandom_range(0, 1) == 0) key_r = 16'($urandom);
                    ct_r = 16'($urandom);
                    bus.in_valid = 1'b1;
                    bus.in_ct    = ct_r;
                    bus.in_key   = key_r;
                    wait_cyc = 0;
                    while (!bus.in_ready && wait_cyc < 200) begin
                        @(negedge clk);
                        wait_cyc++;
                    end
                    if (!bus.in_ready) begin
                        chk("sweep_accept_timeout", 32'(wait_cyc), 32'd0);
                        break;
                    end
                    exp_q.push_back(model_decrypt(ct_r, key_r));
                    sent++;
                    @(posedge clk);
                    #1 bus.in_valid = 1'b0;
                end
                bus.in_valid = 1'b0;
            end
            begin : monitor
                int cyc;
                cyc = 0;
                while (rcvd < 1000 && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                    if (bus.out_valid && bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("sweep_unexpected_output", 32'(bus.out_pt), 32'hFFFF_FFFF);
                        end else begin
                            chk("sweep_pt", 32'(bus.out_pt), 32'(exp_q.pop_front()));
                        end
                        rcvd++;
                        // Let the handshake edge pass so the same beat is not counted twice.
                        @(posedge clk);
                    end
                end
                bus.out_ready = 1'b1;
            end
        join
        chk("sweep_sent", 32'(sent), 32'd1000);
        chk("sweep_received", 32'(rcvd), 32'd1000);
        chk("sweep_leftover", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
